// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] HALT_INSN_C  = 32'h0000_0063;
  localparam logic [31:0] RESET_PC_C   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_C = 128;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2,
    STOPPED   = 2'd3
  } fetch_state_e;

  localparam logic [1:0] ST_RUN       = RUN;
  localparam logic [1:0] ST_HALT_PEND = HALT_PEND;
  localparam logic [1:0] ST_HALTED    = HALTED;
  localparam logic [1:0] ST_STOPPED   = STOPPED;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect, decode handshake and status.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign_err;
  logic        oob_err;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted,
    output misalign_err,
    output oob_err,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  misalign_err,
    input  oob_err,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_out_reg.sv
// One-entry holding register toward decode; flush beats fill beats drain.
// Payload is kept when drained; only the valid bit drops.
module fetch_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        fill_i,
  input  logic        drain_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, redirect/halt FSM, sticky error flags, decode output register.
// Define FETCH_PERF_EN to build the saturating accepted-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_C,
  parameter logic [31:0] HALT_INSN  = HALT_INSN_C
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam logic [29:0] WORD_LIM = 30'(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic        oob_q, oob_d;

  logic in_run, in_pend, redir, accept, load, oob_hit, fill;
  logic out_valid;

  assign in_run  = (state_q == ST_RUN);
  assign in_pend = (state_q == ST_HALT_PEND);
  assign redir   = bus.redirect_valid && (in_run || in_pend);
  assign accept  = out_valid && bus.out_ready;
  assign load    = !out_valid || accept;
  assign oob_hit = (pc_q[31:2] >= WORD_LIM);
  assign fill    = in_run && load && !oob_hit && !redir;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    oob_d      = oob_q;
    if (redir) begin
      // Redirect overrides load and halt capture, and cancels a pending halt.
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      state_d = ST_RUN;
      if (bus.redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load) begin
            if (oob_hit) begin
              oob_d   = 1'b1;
              state_d = ST_STOPPED;
            end else begin
              pc_d = pc_q + 32'd4;
              if (bus.imem_instr == HALT_INSN) state_d = ST_HALT_PEND;
            end
          end
        end
        ST_HALT_PEND: begin
          if (accept) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_RUN;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      oob_q      <= oob_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redir),
    .fill_i  (fill),
    .drain_i (accept),
    .instr_i (bus.imem_instr),
    .pc_i    (pc_q),
    .valid_o (out_valid),
    .instr_o (bus.out_instr),
    .pc_o    (bus.out_pc)
  );

  assign bus.imem_addr    = {pc_q[31:2], 2'b00};
  assign bus.out_valid    = out_valid;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = misalign_q;
  assign bus.oob_err      = oob_q;

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'h0;
    end else if (accept && !redir && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.fetch_count = cnt_q;
`else
  assign bus.fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven stream/stall/redirect vectors plus halt, misalign, oob and async-reset sequences.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic [31:0] halt_addr;
  int n_vec;
  int n_bad;

  fetch_unit_if ifc ();

  fetch_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    return (a == halt_addr) ? 32'h0000_0063 : (32'hA000_0000 | a);
  endfunction

  assign ifc.imem_instr = im(ifc.imem_addr);

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  typedef struct packed {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [2:0]  e_flags;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, check a moment later, then advance one cycle.
  task automatic step(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_pc,
                      input logic [2:0] e_flags, input logic [31:0] e_cnt);
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rpc;
    ifc.out_ready      = rdy;
    #1;
    chk({tag, ".imem_addr"}, ifc.imem_addr, e_addr);
    chk({tag, ".out_valid"}, {31'h0, ifc.out_valid}, {31'h0, e_vld});
    if (e_vld) begin
      chk({tag, ".out_pc"}, ifc.out_pc, e_pc);
      chk({tag, ".out_instr"}, ifc.out_instr, im(e_pc));
    end
    chk({tag, ".flags"}, {29'h0, ifc.halted, ifc.misalign_err, ifc.oob_err}, {29'h0, e_flags});
    chk({tag, ".fetch_count"}, ifc.fetch_count, cnt_exp(e_cnt));
    @(negedge clk);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".imem_addr"}, ifc.imem_addr, 32'h0);
    chk({tag, ".out_valid"}, {31'h0, ifc.out_valid}, 32'h0);
    chk({tag, ".out_instr"}, ifc.out_instr, 32'h0);
    chk({tag, ".out_pc"}, ifc.out_pc, 32'h0);
    chk({tag, ".flags"}, {29'h0, ifc.halted, ifc.misalign_err, ifc.oob_err}, 32'h0);
    chk({tag, ".fetch_count"}, ifc.fetch_count, 32'h0);
  endtask

  task automatic do_reset(input logic [31:0] haddr);
    halt_addr          = haddr;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.out_ready      = 1'b1;
    rst_n              = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    halt_addr = 32'hFFFF_FFF0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.out_ready      = 1'b1;

    //             rv    rpc        rdy   addr       vld   out_pc     flags  cnt
    tbl[0]  = '{1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h00, 3'b000, 32'd0};
    tbl[1]  = '{1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'h00, 3'b000, 32'd0};
    tbl[2]  = '{1'b0, 32'h0,  1'b0, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h08, 3'b000, 32'd2};
    tbl[7]  = '{1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h0C, 3'b000, 32'd3};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h00, 3'b000, 32'd3};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40, 3'b000, 32'd3};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h44, 3'b000, 32'd4};

    // Stream, stall at pc=8, redirect flushing an accepted word.
    do_reset(32'hFFFF_FFF0);
    for (int i = 0; i < 11; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].e_addr,
           tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_flags, tbl[i].e_cnt);
    end

    // Halt word at 0x10: presented, held, consumed, then redirects ignored.
    do_reset(32'h10);
    step("h0", 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h00, 3'b000, 32'd0);
    step("h1", 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'h00, 3'b000, 32'd0);
    step("h2", 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1);
    step("h3", 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h08, 3'b000, 32'd2);
    step("h4", 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h0C, 3'b000, 32'd3);
    step("h5", 1'b0, 32'h0,  1'b0, 32'h14, 1'b1, 32'h10, 3'b000, 32'd4);
    chk("h5.halt_word", ifc.out_instr, 32'h0000_0063);
    step("h6", 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h10, 3'b000, 32'd4);
    step("h7", 1'b1, 32'h80, 1'b1, 32'h14, 1'b0, 32'h00, 3'b100, 32'd5);
    step("h8", 1'b0, 32'h0,  1'b1, 32'h14, 1'b0, 32'h00, 3'b100, 32'd5);
    step("h9", 1'b0, 32'h0,  1'b1, 32'h14, 1'b0, 32'h00, 3'b100, 32'd5);

    // Misaligned redirect cancels the pending halt, then async reset mid-stall.
    do_reset(32'h10);
    step("m0", 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h00, 3'b000, 32'd0);
    step("m1", 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'h00, 3'b000, 32'd0);
    step("m2", 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h04, 3'b000, 32'd1);
    step("m3", 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h08, 3'b000, 32'd2);
    step("m4", 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h0C, 3'b000, 32'd3);
    step("m5", 1'b1, 32'h22, 1'b0, 32'h14, 1'b1, 32'h10, 3'b000, 32'd4);
    step("m6", 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h00, 3'b010, 32'd4);
    step("m7", 1'b0, 32'h0,  1'b0, 32'h24, 1'b1, 32'h20, 3'b010, 32'd4);
    step("m8", 1'b0, 32'h0,  1'b0, 32'h24, 1'b1, 32'h20, 3'b010, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("async_rst");
    @(negedge clk);
    halt_addr = 32'hFFFF_FFF0;
    rst_n = 1'b1;

    // Run past the last valid word index.
    step("o0", 1'b1, 32'h1F8, 1'b1, 32'h000, 1'b0, 32'h000, 3'b000, 32'd0);
    step("o1", 1'b0, 32'h0,   1'b1, 32'h1F8, 1'b0, 32'h000, 3'b000, 32'd0);
    step("o2", 1'b0, 32'h0,   1'b1, 32'h1FC, 1'b1, 32'h1F8, 3'b000, 32'd0);
    step("o3", 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h1FC, 3'b000, 32'd1);
    step("o4", 1'b1, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000, 3'b001, 32'd2);
    step("o5", 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000, 3'b001, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
